// File: rtl/memory_master.sv
// Burst memory master: issues 1..16 beat read/write bursts to a simple
// fixed-latency memory. Optional read-back compare enabled by MEMORY_MASTER_RDCHK_EN.
module memory_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        advance_s;
  logic [3:0]  beat_r;
  logic [3:0]  len_r;
  logic        wr_pend_r;
  logic        rd_pend_r;
  logic        err_flag_r;
  logic        wr_fail_s;
  logic        rd_fail_s;
  logic        err_next_s;

  assign cmd_ready = (state_r == IDLE);

  // Next-state decode and beat sequencing enables
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          next_state_s = ISSUE;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (beat_r == len_r) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ISSUE;
          advance_s    = 1'b1;
        end
      end
      DRAIN:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

`ifdef MEMORY_MASTER_RDCHK_EN
  logic [DATA_WIDTH-1:0] rd_exp_r;

  // Expected read value tracks seed + beat index of the next captured beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_exp_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      rd_exp_r <= cmd_wdata;
    end else if (rd_pend_r) begin
      rd_exp_r <= rd_exp_r + DATA_WIDTH'(1);
    end else begin
      rd_exp_r <= rd_exp_r;
    end
  end
`endif

  // Per-cycle error sources; a write beat is acknowledged one cycle after issue
  always_comb begin
    wr_fail_s = wr_pend_r & ~mem_response;
`ifdef MEMORY_MASTER_RDCHK_EN
    rd_fail_s = rd_pend_r & (mem_rdata != rd_exp_r);
`else
    rd_fail_s = 1'b0;
`endif
    err_next_s = err_flag_r | wr_fail_s | rd_fail_s;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Beat issue, response capture and completion status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_r     <= 4'd0;
      len_r      <= 4'd0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      mem_wdata  <= {DATA_WIDTH{1'b0}};
      wr_pend_r  <= 1'b0;
      rd_pend_r  <= 1'b0;
      err_flag_r <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= {DATA_WIDTH{1'b0}};
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_pend_r <= mem_wr;
      rd_pend_r <= mem_rd;
      rsp_valid <= rd_pend_r;
      if (rd_pend_r) begin
        rsp_data <= mem_rdata;
      end
      done <= (state_r == DRAIN);
      // The last beat's check lands on the DRAIN edge, so err takes the live value
      if (state_r == DRAIN) begin
        err <= err_next_s;
      end
      if (accept_s) begin
        beat_r     <= 4'd0;
        len_r      <= cmd_len;
        mem_wr     <= cmd_write;
        mem_rd     <= ~cmd_write;
        mem_addr   <= cmd_addr;
        mem_wdata  <= cmd_wdata;
        err_flag_r <= 1'b0;
      end else if (advance_s) begin
        beat_r     <= beat_r + 4'd1;
        mem_addr   <= mem_addr + ADDR_WIDTH'(1);
        mem_wdata  <= mem_wdata + DATA_WIDTH'(1);
        err_flag_r <= err_next_s;
      end else begin
        mem_wr     <= 1'b0;
        mem_rd     <= 1'b0;
        err_flag_r <= err_next_s;
      end
    end
  end

endmodule

// File: doc/memory_master.md
MEMORY_MASTER -- requirements
Module: memory_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: memory data width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  burst command offered.
REQ-006 cmd_ready  output  1  block idle and able to accept a command.
REQ-007 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  ADDR_WIDTH  start address.
REQ-009 cmd_len  input  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-010 cmd_wdata  input  DATA_WIDTH  seed; write beat i carries cmd_wdata+i.
REQ-011 mem_wr  output  1  memory write strobe.
REQ-012 mem_rd  output  1  memory read strobe.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address.
REQ-014 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-015 mem_rdata  input  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd, high-Z otherwise.
REQ-016 mem_response  input  1  memory write acknowledge, high 1 cycle after mem_wr.
REQ-017 rsp_valid  output  1  one-cycle pulse per captured read beat.
REQ-018 rsp_data  output  DATA_WIDTH  captured read data.
REQ-019 done  output  1  one-cycle pulse at burst completion.
REQ-020 err  output  1  error status of the last completed burst, held until next done.

Function
REQ-021 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on cmd_valid&&cmd_ready; ISSUE->DRAIN after beat cmd_len issued; DRAIN->IDLE after one cycle.
REQ-022 cmd_ready = 1 only in IDLE; cmd_valid outside IDLE is ignored; command fields are latched at acceptance edge.
REQ-023 mem_wr, mem_rd, mem_addr, mem_wdata are registered; beat i is driven in the (i+1)th ISSUE cycle, one beat per cycle, no gaps.
REQ-024 mem_wr and mem_rd are never both high; both low outside ISSUE.
REQ-025 Beat address = (cmd_addr+i) mod 2^ADDR_WIDTH; 15 wraps to 0; data sum truncated to DATA_WIDTH.
REQ-026 Write beat issued in cycle t: mem_response sampled in cycle t+1; if low, burst error flag set (sticky for that burst).
REQ-027 Read beat issued in cycle t: mem_rdata captured at end of cycle t+1; rsp_valid=1, rsp_data=captured value in cycle t+2.
REQ-028 done=1 in the first IDLE cycle after DRAIN; err updated to burst error flag in the same cycle; last rsp_valid coincides with done.
REQ-029 A new command may be accepted in the same cycle done is high.
REQ-030 1-beat write accepted at edge E0: mem_wr high cycle 1, response checked cycle 2, done cycle 3.

Reset
REQ-031 reset_n low immediately forces IDLE; mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, done=0, err=0, cmd_ready=1 after release.
REQ-032 Reset mid-burst abandons the burst with no done pulse; remaining beats are never issued.

Configuration
REQ-033 Macro MEMORY_MASTER_RDCHK_EN defined: each read beat i compared with cmd_wdata+i; mismatch sets burst error flag.
REQ-034 Macro undefined: no read compare; err reflects write-response failures only; read bursts always complete with err=0.

Verification
REQ-035 Write cmd_addr=3, cmd_len=3, cmd_wdata=0x10 -> mem_wr 4 consecutive cycles, addr 3,4,5,6, data 0x10..0x13; done with err=0.
REQ-036 Read cmd_addr=3, cmd_len=3 after REQ-035 -> 4 rsp_valid pulses, rsp_data 0x10..0x13; done with err=0.
REQ-037 Write cmd_addr=14, cmd_len=3 -> mem_addr 14,15,0,1.
REQ-038 Write with mem_response forced low on beat 2 -> done with err=1; next good burst -> err=0.
REQ-039 reset_n low during beat 2 of 8-beat write -> mem_wr low immediately, no done, cmd_ready=1 after release.
REQ-040 RDCHK_EN defined, read after memory location 5 overwritten with 0xDEAD -> err=1; undefined -> err=0.
